// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and defaults for the data-memory port arbiter
package mips_pkg;
  typedef enum logic {
    ARB_FIRST  = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_e;
  localparam int MIPS_DATA_W = 32;
endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises both M-stage lanes onto one data-memory port, lane 1 first
//   clk, reset            clock, async active-high reset
//   MemRead/Write{1,2}M   lane load/store requests; ALUOut/WriteData{1,2}M address and store data
//   MemRData, MemReady    memory read data and completion handshake (may be combinational)
//   MemRE/WE/Addr/WData   memory request toward the single port
//   ReadData{1,2}M        lane load results; MemStallM holds F..M; StallCount saturating stall cycles
module dmem_port_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead1M,
  input  logic              MemWrite1M,
  input  logic [DATA_W-1:0] ALUOut1M,
  input  logic [DATA_W-1:0] WriteData1M,
  input  logic              MemRead2M,
  input  logic              MemWrite2M,
  input  logic [DATA_W-1:0] ALUOut2M,
  input  logic [DATA_W-1:0] WriteData2M,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemReady,
  output logic              MemRE,
  output logic              MemWE,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic [DATA_W-1:0] ReadData1M,
  output logic [DATA_W-1:0] ReadData2M,
  output logic              MemStallM,
  output logic [CNT_W-1:0]  StallCount
);
  arb_state_e        r_state, w_next;
  logic [DATA_W-1:0] r_rdata1;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_req1, w_req2, w_sel1, w_sel2;
  assign w_req1 = MemRead1M | MemWrite1M;
  assign w_req2 = MemRead2M | MemWrite2M;
  assign w_sel1 = (r_state == ARB_FIRST) && w_req1;
  // In SECOND lane 2 owns the port unconditionally: M inputs are frozen by the stall
  assign w_sel2 = (r_state == ARB_SECOND) || (!w_req1 && w_req2);
  // A lane asserting both read and write is treated as a write
  always_comb begin
    MemWE      = w_sel1 ? MemWrite1M : w_sel2 ? MemWrite2M : 1'b0;
    MemRE      = w_sel1 ? (MemRead1M & ~MemWrite1M) : w_sel2 ? (MemRead2M & ~MemWrite2M) : 1'b0;
    MemAddr    = w_sel1 ? ALUOut1M : w_sel2 ? ALUOut2M : '0;
    MemWData   = w_sel1 ? WriteData1M : w_sel2 ? WriteData2M : '0;
    MemStallM  = w_sel1 ? (!MemReady || w_req2) : (w_sel2 && !MemReady);
    ReadData1M = w_sel1 ? MemRData : r_rdata1;
    ReadData2M = w_sel2 ? MemRData : '0;
    w_next     = (r_state == ARB_FIRST) ? ((w_sel1 && MemReady && w_req2) ? ARB_SECOND : ARB_FIRST)
                                        : (MemReady ? ARB_FIRST : ARB_SECOND);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_FIRST;
      r_rdata1    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_sel1 && MemReady) r_rdata1 <= MemRData;
      if (MemStallM && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
  assign StallCount = r_stall_cnt;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random checks against a transaction-level memory model
module tb_dmem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemRead1M = 0, MemWrite1M = 0, MemRead2M = 0, MemWrite2M = 0, MemReady = 0;
  logic [31:0] ALUOut1M = 0, WriteData1M = 0, ALUOut2M = 0, WriteData2M = 0, MemRData = 0;
  logic        MemRE, MemWE, MemStallM;
  logic [31:0] MemAddr, MemWData, ReadData1M, ReadData2M, StallCount;
  int          checks = 0, failures = 0, exp_stalls = 0;
  logic [31:0] mem [16];

  dmem_port_arbiter #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemRead1M(MemRead1M), .MemWrite1M(MemWrite1M), .ALUOut1M(ALUOut1M), .WriteData1M(WriteData1M),
    .MemRead2M(MemRead2M), .MemWrite2M(MemWrite2M), .ALUOut2M(ALUOut2M), .WriteData2M(WriteData2M),
    .MemRData(MemRData), .MemReady(MemReady),
    .MemRE(MemRE), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .ReadData1M(ReadData1M), .ReadData2M(ReadData2M), .MemStallM(MemStallM), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one M-stage instruction pair; called and returns at posedge+1.
  task automatic run_pair(input bit rd1, input bit wr1, input logic [31:0] a1, input logic [31:0] d1,
                          input bit rd2, input bit wr2, input logic [31:0] a2, input logic [31:0] d2,
                          input int wt1, input int wt2);
    int          lanes[$];
    logic [31:0] data1;
    bit          rd, wr, last;
    logic [31:0] a, d;
    int          wt;
    MemRead1M = rd1; MemWrite1M = wr1; ALUOut1M = a1; WriteData1M = d1;
    MemRead2M = rd2; MemWrite2M = wr2; ALUOut2M = a2; WriteData2M = d2;
    data1 = 'x;
    if (rd1 | wr1) lanes.push_back(1);
    if (rd2 | wr2) lanes.push_back(2);
    if (lanes.size() == 0) begin
      MemReady = $urandom_range(0, 1); MemRData = $urandom;
      #4;
      chk("idle_re", {31'b0, MemRE}, 0);
      chk("idle_we", {31'b0, MemWE}, 0);
      chk("idle_addr", MemAddr, 0);
      chk("idle_stall", {31'b0, MemStallM}, 0);
      @(posedge clk); #1;
    end
    foreach (lanes[k]) begin
      rd = (lanes[k] == 1) ? rd1 : rd2;
      wr = (lanes[k] == 1) ? wr1 : wr2;
      a  = (lanes[k] == 1) ? a1 : a2;
      d  = (lanes[k] == 1) ? d1 : d2;
      wt = (lanes[k] == 1) ? wt1 : wt2;
      for (int c = 0; c <= wt; c++) begin
        last = (k == lanes.size() - 1) && (c == wt);
        MemReady = (c == wt);
        MemRData = (c == wt && rd && !wr) ? mem[a[5:2]] : $urandom;
        #4;
        chk("addr", MemAddr, a);
        chk("re", {31'b0, MemRE}, {31'b0, rd & ~wr});
        chk("we", {31'b0, MemWE}, {31'b0, wr});
        if (wr) chk("wdata", MemWData, d);
        chk("stall", {31'b0, MemStallM}, {31'b0, !last});
        if (c == wt) begin
          if (rd && !wr && lanes[k] == 1) data1 = mem[a[5:2]];
          if (rd && !wr && lanes[k] == 2) chk("rdata2", ReadData2M, mem[a[5:2]]);
          if (last && rd1 && !wr1) chk("rdata1", ReadData1M, data1);
          if (wr) mem[a[5:2]] = d;
        end
        if (!last) exp_stalls++;
        @(posedge clk); #1;
      end
    end
    chk("stall_count", StallCount, exp_stalls);
    MemRead1M = 0; MemWrite1M = 0; MemRead2M = 0; MemWrite2M = 0; MemReady = 0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    chk("rst_stall", {31'b0, MemStallM}, 0);
    chk("rst_rdata1", ReadData1M, 0);
    chk("rst_count", StallCount, 0);
    @(posedge clk); #1;
    mem[4'h4] = 32'hA5A5_A5A5;
    run_pair(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    mem[4'h8] = 32'h11; mem[4'h9] = 32'h22;
    run_pair(1, 0, 32'h20, 0, 1, 0, 32'h24, 0, 0, 0);
    run_pair(0, 1, 32'h40, 32'h6969_6969, 1, 0, 32'h40, 0, 0, 0);
    chk("sw_lw_fwd", mem[0], 32'h6969_6969);
    run_pair(0, 0, 0, 0, 0, 1, 32'h2C, 32'hDEAD_BEEF, 0, 3);
    run_pair(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_pair(1, 1, 32'h30, 32'h1234_5678, 1, 0, 32'h30, 0, 1, 1);
    for (int n = 0; n < 300; n++)
      run_pair($urandom_range(0, 1), $urandom_range(0, 3) == 0, {$urandom_range(0, 15), 2'b00}, $urandom,
               $urandom_range(0, 1), $urandom_range(0, 3) == 0, {$urandom_range(0, 15), 2'b00}, $urandom,
               $urandom_range(0, 2), $urandom_range(0, 2));
    MemRead1M = 1; ALUOut1M = 32'h08; MemRead2M = 1; ALUOut2M = 32'h0C;
    MemReady = 1; MemRData = 32'h5555_AAAA;
    @(posedge clk); #1;
    MemReady = 0;
    #4;
    chk("mid_stall", {31'b0, MemStallM}, 1);
    chk("mid_addr", MemAddr, 32'h0C);
    chk("mid_rdata1", ReadData1M, 32'h5555_AAAA);
    #1;
    reset = 1'b1;
    MemRead1M = 0; MemRead2M = 0;
    #1;
    chk("arst_stall", {31'b0, MemStallM}, 0);
    chk("arst_rdata1", ReadData1M, 0);
    chk("arst_count", StallCount, 0);
    exp_stalls = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    mem[4'h1] = 32'hCAFE_0001;
    run_pair(1, 0, 32'h04, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the two M-stage lanes of the dual-issue pipeline.
- Serialises same-cycle accesses in program order: lane 1 is older, so it is always served first.
- Accepts variable-latency memory via a ready handshake.
- Raises MemStallM to the hazard unit while any M-stage access is incomplete, and holds lane 1 load data until both lanes finish.

Parameters:
- DATA_W, 32, data and address width.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- MemRead1M  in  1  lane 1 load in M
- MemWrite1M  in  1  lane 1 store in M
- ALUOut1M  in  DATA_W  lane 1 address
- WriteData1M  in  DATA_W  lane 1 store data
- MemRead2M  in  1  lane 2 load in M
- MemWrite2M  in  1  lane 2 store in M
- ALUOut2M  in  DATA_W  lane 2 address
- WriteData2M  in  DATA_W  lane 2 store data
- MemRData  in  DATA_W  memory read data, valid when MemReady=1
- MemReady  in  1  memory completes the presented access this cycle; may be combinational (zero-wait)
- MemRE  out  1  memory read request
- MemWE  out  1  memory write request
- MemAddr  out  DATA_W  memory address
- MemWData  out  DATA_W  memory write data
- ReadData1M  out  DATA_W  lane 1 load result
- ReadData2M  out  DATA_W  lane 2 load result
- MemStallM  out  1  stall F through M and hold all M-stage inputs stable
- StallCount  out  CNT_W  saturating count of cycles with MemStallM=1

Behaviour:
- Definitions: Req1 = MemRead1M | MemWrite1M; Req2 = MemRead2M | MemWrite2M.
- Read and write asserted together on one lane is illegal; treat it as a write.
- States: FIRST and SECOND. Reset state is FIRST.
- Reset values: RData1Q=0, StallCount=0. All outputs are combinational from state and inputs.
- FIRST, Req1=1:
  - Memory driven from lane 1.
  - On MemReady: RData1Q <= MemRData. If Req2, go to SECOND; else stay in FIRST.
  - MemStallM = !MemReady | Req2.
- FIRST, Req1=0 and Req2=1:
  - Memory driven from lane 2. MemStallM = !MemReady. Stay in FIRST.
- FIRST, no request:
  - MemRE=MemWE=0, MemAddr=0, MemWData=0, MemStallM=0.
- SECOND:
  - Memory driven from lane 2. MemStallM = !MemReady.
  - On MemReady, go to FIRST.
- ReadData1M: MemRData when in FIRST serving lane 1; RData1Q when in SECOND.
- ReadData2M: MemRData whenever lane 2 is being served; otherwise 0.
- Latency: a single request with zero-wait memory costs 0 stall cycles. A dual request with zero-wait memory costs exactly 1 stall cycle. Each memory wait cycle adds 1 stall cycle.
- Ordering: lane 1 store then lane 2 load to the same address returns the newly stored data. No forwarding is needed because access is serialised.
- Memory requests are never aborted by the arbiter. Flush of M is suppressed by the hazard unit while MemStallM=1.
- StallCount increments on each clock edge where MemStallM=1 and saturates at all-ones.
- Reset mid-access: asynchronous reset returns the FSM to FIRST immediately and clears RData1Q and StallCount. Requests drop in the same cycle.

Decomposition:
- Shared package mips_pkg holds: state encodings (ARB_FIRST=1'b0, ARB_SECOND=1'b1) and DATA_W default 32.
- No sub-module; the block is a single FSM with one data register and one counter.

Test Plan:
- Lane 1 lw only, addr 0x10, MemReady=1 (combinational), MemRData=0xA5A5A5A5 -> MemRE=1, MemAddr=0x10, ReadData1M=0xA5A5A5A5, MemStallM=0, StallCount stays 0.
- Lane 1 lw 0x20 and lane 2 lw 0x24, zero-wait memory returning 0x11 then 0x22 -> cycle 0: MemAddr=0x20, MemStallM=1. Cycle 1: SECOND, MemAddr=0x24, ReadData1M=0x11, ReadData2M=0x22, MemStallM=0. StallCount=1.
- Lane 1 sw 0x69696969 to 0x40 and lane 2 lw 0x40, backing model -> first access has MemWE=1 with MemWData=0x69696969; second access returns ReadData2M=0x69696969.
- Lane 2 sw only, MemReady low for 3 cycles then high -> MemStallM=1 for 3 cycles and 0 on the 4th. MemWE held with stable addr/data all 4 cycles. StallCount=3.
- Dual request, reset asserted while in SECOND with MemReady=0 -> state returns to FIRST asynchronously, MemStallM=0 with inputs deasserted, RData1Q=0, StallCount=0.
